hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Control side of the EX-stage operand muxes and the ID-stage branch-compare muxes in the pipelined MIPS core.
//  Keeps its own shadow copy of the destination and control fields for the EX, MEM and WB stages.
//  From those it drives the 2-bit forward selects (00 = ID/EX value, 01 = WB result, 10 = MEM ALU result).
//  It also drives the load-use/branch stall and EX flush controls, and a saturating stall-cycle counter.
// PARAMETERS
//  REG_ADDR_WIDTH  5   register-file address width
//  CNT_WIDTH       16  stall-cycle counter width
// PORTS
//  clk            in   1       core clock, all state updates on rising edge
//  rst            in   1       asynchronous, active-high reset
//  id_valid       in   1       ID stage holds a real instruction
//  id_rs          in   RAW     source register A of ID instruction
//  id_rt          in   RAW     source register B of ID instruction
//  id_dst         in   RAW     destination register chosen in ID (rt or rd)
//  id_reg_write   in   1       ID instruction writes the register file
//  id_mem_to_reg  in   1       ID instruction is a load
//  id_branch      in   1       ID instruction is a branch compared in ID
//  forward_a_e    out  2       select for EX operand A mux
//  forward_b_e    out  2       select for EX operand B mux
//  forward_a_d    out  1       ID branch operand A takes MEM ALU result
//  forward_b_d    out  1       ID branch operand B takes MEM ALU result
//  stall_f        out  1       hold PC
//  stall_d        out  1       hold IF/ID register
//  flush_e        out  1       clear ID/EX register (insert bubble)
//  stall_count    out  CNT_W   number of stalled cycles since reset, saturating
// BEHAVIOUR
//  - Shadow registers, each stage has {valid, rs, rt, dst, reg_write, mem_to_reg}: EX, MEM, WB.
//  - rst (async): all shadow fields 0 and stall_count 0. All outputs then evaluate to 0.
//  - Every edge, when stall = 0:
//    - EX <= ID fields.
//    - reg_write and mem_to_reg are gated by id_valid.
//  - Every edge, when stall = 1:
//    - EX <= bubble: all fields 0.
//    - The ID fields are not captured; ID re-presents them next cycle.
//  - MEM <= EX and WB <= MEM every edge, unconditionally.
//  - Register $0 is never a hazard source. Any compare with address 0 is false.
//  - lwstall = id_valid & EX.mem_to_reg & EX.reg_write & EX.dst!=0 & (EX.dst==id_rs | EX.dst==id_rt).
//  - brstall = id_valid & id_branch & [ (EX.reg_write & EX.dst!=0 & EX.dst in {id_rs,id_rt})
//              | (MEM.mem_to_reg & MEM.dst!=0 & MEM.dst in {id_rs,id_rt}) ].
//  - stall = lwstall | brstall. stall_f = stall_d = flush_e = stall (combinational, same cycle).
//  - forward_a_e:
//    - 10 if EX.rs!=0 & MEM.reg_write & MEM.dst==EX.rs.
//    - else 01 if EX.rs!=0 & WB.reg_write & WB.dst==EX.rs.
//    - else 00.
//    - MEM has priority over WB when both match. Encoding 11 is never driven.
//  - forward_b_e: same rule using EX.rt.
//  - forward_a_d = id_rs!=0 & MEM.reg_write & ~MEM.mem_to_reg & MEM.dst==id_rs. forward_b_d: same rule using id_rt.
//  - No WB->ID forwarding. The register file writes in the first half-cycle and reads in the second.
//  - stall_count increments on each edge where stall = 1. It holds at all-ones, with no wrap.
//  - Forward, stall and flush outputs are combinational from shadow state and ID inputs. There is no added latency.
//  - Reset mid-stall: the bubble and counter are cleared immediately. The first post-reset edge captures the ID fields normally.
// TESTING
//  - Reset: assert rst asynchronously mid-cycle -> all outputs 0 and stall_count 0 before the next clk edge.
//  - add $3 in ID, next cycle sub rs=$3 in ID -> one cycle later forward_a_e=10; with a nop between -> forward_a_e=01.
//  - Double hit: add $3, add $3, sub rs=$3 -> forward_a_e=10 (MEM priority, not 01).
//  - Load-use: lw dst=$5, then add rt=$5 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle.
//    Next cycle forward_b_e=01; stall_count goes 0->1.
//  - Branch: add $2, then beq rs=$2 -> 1 stall cycle, then forward_a_d=1.
//    lw $2, then beq rs=$2 -> 2 stall cycles, forward_a_d stays 0.
//  - $0 and saturation: add dst=$0, then sub rs=$0 -> forward_a_e=00, no stall.
//    With CNT_WIDTH=4, force 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding control for the five-stage MIPS pipeline.
// Tracks EX/MEM/WB destination state locally and drives forward, stall and flush selects.
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic [REG_ADDR_WIDTH-1:0] id_dst,
    input  logic                      id_reg_write,
    input  logic                      id_mem_to_reg,
    input  logic                      id_branch,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic                      forward_a_d,
    output logic                      forward_b_d,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_e,
    output logic [CNT_WIDTH-1:0]      stall_count
);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

    typedef struct packed {
        logic valid;
        reg_t rs;
        reg_t rt;
        reg_t dst;
        logic reg_write;
        logic mem_to_reg;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    stage_t id_s;
    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    logic lwstall;
    logic brstall;
    logic stall;

    // $0 is hardwired to zero, so it can never carry a dependency.
    function automatic logic hit(input reg_t dst, input reg_t src);
        return (dst != '0) && (dst == src);
    endfunction

    function automatic logic hit2(input reg_t dst, input reg_t a, input reg_t b);
        return hit(dst, a) || hit(dst, b);
    endfunction

    // MEM result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_e(input reg_t src,
                                         input stage_t mem,
                                         input stage_t wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem.valid && mem.reg_write && hit(mem.dst, src)) begin
            sel = 2'b10;
        end else if (wb.valid && wb.reg_write && hit(wb.dst, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    function automatic logic fwd_d(input reg_t src, input stage_t mem);
        return mem.valid && mem.reg_write && !mem.mem_to_reg
               && hit(mem.dst, src);
    endfunction

    always_comb begin
        id_s            = BUBBLE;
        id_s.valid      = id_valid;
        id_s.rs         = id_rs;
        id_s.rt         = id_rt;
        id_s.dst        = id_dst;
        id_s.reg_write  = id_reg_write & id_valid;
        id_s.mem_to_reg = id_mem_to_reg & id_valid;
    end

    always_comb begin
        lwstall = id_valid
                  & ex_q.valid
                  & ex_q.mem_to_reg
                  & ex_q.reg_write
                  & hit2(ex_q.dst, id_rs, id_rt);

        // A branch resolved in ID must wait for any ALU result still in EX
        // and for any load result still in MEM.
        brstall = id_valid
                  & id_branch
                  & ((ex_q.valid & ex_q.reg_write
                      & hit2(ex_q.dst, id_rs, id_rt))
                     | (mem_q.valid & mem_q.mem_to_reg
                        & hit2(mem_q.dst, id_rs, id_rt)));

        stall = lwstall | brstall;
    end

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    assign forward_a_e = fwd_e(ex_q.rs, mem_q, wb_q);
    assign forward_b_e = fwd_e(ex_q.rt, mem_q, wb_q);
    assign forward_a_d = fwd_d(id_rs, mem_q);
    assign forward_b_d = fwd_d(id_rt, mem_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= BUBBLE;
        end else begin
            ex_q  <= stall ? BUBBLE : id_s;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    // Source fields travel down the pipe for debug visibility only.
    logic unused_fields;
    assign unused_fields = ^{mem_q.rs, mem_q.rt,
                             wb_q.rs, wb_q.rt, wb_q.mem_to_reg};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed checks of forwarding, stall, flush and stall counter behaviour.
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_dst;
    logic       id_reg_write;
    logic       id_mem_to_reg;
    logic       id_branch;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       forward_a_d;
    logic       forward_b_d;
    logic       stall_f;
    logic       stall_d;
    logic       flush_e;
    logic [3:0] stall_count;

    int errors = 0;
    int checks = 0;

    hazard_forward_unit #(
        .REG_ADDR_WIDTH(5),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(id_valid),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .id_dst(id_dst),
        .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch),
        .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d),
        .forward_b_d(forward_b_d),
        .stall_f(stall_f),
        .stall_d(stall_d),
        .flush_e(flush_e),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".stall_f"}, {31'd0, stall_f}, {31'd0, exp});
        chk({tag, ".stall_d"}, {31'd0, stall_d}, {31'd0, exp});
        chk({tag, ".flush_e"}, {31'd0, flush_e}, {31'd0, exp});
    endtask

    task automatic chk_fe(input string tag, input logic [1:0] a,
                          input logic [1:0] b);
        chk({tag, ".fa_e"}, {30'd0, forward_a_e}, {30'd0, a});
        chk({tag, ".fb_e"}, {30'd0, forward_b_e}, {30'd0, b});
    endtask

    task automatic chk_fd(input string tag, input logic a, input logic b);
        chk({tag, ".fa_d"}, {31'd0, forward_a_d}, {31'd0, a});
        chk({tag, ".fb_d"}, {31'd0, forward_b_d}, {31'd0, b});
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp);
        chk({tag, ".cnt"}, {28'd0, stall_count}, {28'd0, exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk_stall(tag, 1'b0);
        chk_fe(tag, 2'b00, 2'b00);
        chk_fd(tag, 1'b0, 1'b0);
        chk_cnt(tag, 4'd0);
    endtask

    // Wait for the falling edge, present an ID instruction, settle.
    task automatic drive(input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] dst,
                         input logic rw, input logic m2r, input logic br);
        @(negedge clk);
        id_valid      = v;
        id_rs         = rs;
        id_rt         = rt;
        id_dst        = dst;
        id_reg_write  = rw;
        id_mem_to_reg = m2r;
        id_branch     = br;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush_pipe();
        nop();
        nop();
        nop();
        nop();
    endtask

    initial begin
        rst           = 1'b1;
        id_valid      = 1'b0;
        id_rs         = '0;
        id_rt         = '0;
        id_dst        = '0;
        id_reg_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        id_branch     = 1'b0;
        #1;
        chk_all_zero("reset");
        #12;
        rst = 1'b0;

        // Load-use: lw $5 then add rt=$5
        drive(1, 5'd1, 5'd5, 5'd5, 1, 1, 0);
        chk_stall("lw_issue", 1'b0);
        drive(1, 5'd4, 5'd5, 5'd6, 1, 0, 0);
        chk_stall("lu_stall", 1'b1);
        chk_cnt("lu_cnt0", 4'd0);
        drive(1, 5'd4, 5'd5, 5'd6, 1, 0, 0);
        chk_stall("lu_release", 1'b0);
        chk_cnt("lu_cnt1", 4'd1);
        nop();
        chk_fe("lu_fwd", 2'b00, 2'b01);
        chk_stall("lu_after", 1'b0);
        flush_pipe();

        // add $3 ; sub rs=$3 -> MEM forward
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
        drive(1, 5'd3, 5'd4, 5'd6, 1, 0, 0);
        chk_stall("ex_dep_nostall", 1'b0);
        nop();
        chk_fe("mem_fwd", 2'b10, 2'b00);
        flush_pipe();

        // add $3 ; nop ; sub rs=$3 -> WB forward
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
        nop();
        drive(1, 5'd3, 5'd4, 5'd6, 1, 0, 0);
        nop();
        chk_fe("wb_fwd", 2'b01, 2'b00);
        flush_pipe();

        // Double hit: MEM has priority
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
        drive(1, 5'd3, 5'd3, 5'd6, 1, 0, 0);
        nop();
        chk_fe("dbl_hit", 2'b10, 2'b10);
        flush_pipe();

        // Branch after ALU op: one stall then ID forward
        drive(1, 5'd1, 5'd1, 5'd2, 1, 0, 0);
        drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
        chk_stall("br_alu_s1", 1'b1);
        chk_fd("br_alu_s1", 1'b0, 1'b0);
        drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
        chk_stall("br_alu_go", 1'b0);
        chk_fd("br_alu_go", 1'b1, 1'b0);
        chk_cnt("br_alu_cnt", 4'd2);
        flush_pipe();

        // Branch after load: two stalls, no ID forward
        drive(1, 5'd1, 5'd1, 5'd2, 1, 1, 0);
        drive(1, 5'd7, 5'd2, 5'd0, 0, 0, 1);
        chk_stall("br_lw_s1", 1'b1);
        drive(1, 5'd7, 5'd2, 5'd0, 0, 0, 1);
        chk_stall("br_lw_s2", 1'b1);
        chk_fd("br_lw_s2", 1'b0, 1'b0);
        drive(1, 5'd7, 5'd2, 5'd0, 0, 0, 1);
        chk_stall("br_lw_go", 1'b0);
        chk_fd("br_lw_go", 1'b0, 1'b0);
        chk_cnt("br_lw_cnt", 4'd4);
        flush_pipe();

        // Register $0 never forwards or stalls
        drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 0);
        drive(1, 5'd0, 5'd0, 5'd6, 1, 0, 1);
        chk_stall("zero_br", 1'b0);
        nop();
        chk_fe("zero_fwd", 2'b00, 2'b00);
        drive(1, 5'd1, 5'd2, 5'd0, 1, 1, 0);
        drive(1, 5'd0, 5'd0, 5'd6, 1, 0, 0);
        chk_stall("zero_lw", 1'b0);
        flush_pipe();

        // Invalid ID slot never stalls and never writes
        drive(1, 5'd1, 5'd2, 5'd9, 1, 1, 0);
        drive(0, 5'd9, 5'd9, 5'd0, 0, 0, 1);
        chk_stall("inv_id", 1'b0);
        drive(0, 5'd1, 5'd2, 5'd8, 1, 0, 0);
        drive(1, 5'd8, 5'd8, 5'd6, 1, 0, 0);
        nop();
        chk_fe("inv_nowr", 2'b00, 2'b00);
        flush_pipe();
        chk_cnt("pre_sat", 4'd4);

        // Saturation: five lw/beq pairs add 10 stalls, counter reaches 14
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd1, 5'd1, 5'd2, 1, 1, 0);
            drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
            drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
            drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
        end
        nop();
        chk_cnt("sat_14", 4'd14);
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'd1, 5'd1, 5'd2, 1, 1, 0);
            drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
            drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
            drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
        end
        nop();
        chk_cnt("sat_15", 4'd15);

        // Async reset in the middle of a stall cycle
        drive(1, 5'd1, 5'd1, 5'd2, 1, 1, 0);
        drive(1, 5'd2, 5'd7, 5'd0, 0, 0, 1);
        chk_stall("pre_rst", 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;

        // First edge after reset captures ID normally
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0);
        drive(1, 5'd4, 5'd3, 5'd6, 1, 0, 0);
        chk_stall("post_rst", 1'b0);
        nop();
        chk_fe("post_rst", 2'b00, 2'b10);
        chk_cnt("post_rst", 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
